// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: excepttype codes, MEM
// exception flag positions, stall vectors, CP0 Status/Cause field positions,
// FSM state encodings and the interrupt-pending helper.
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam int FLAG_ADEL_IF = 0;
  localparam int FLAG_RI      = 1;
  localparam int FLAG_OV      = 2;
  localparam int FLAG_TRAP    = 3;
  localparam int FLAG_SYS     = 4;
  localparam int FLAG_ADEL_D  = 5;
  localparam int FLAG_ADES    = 6;
  localparam int FLAG_ERET    = 7;

  // {wb,mem,ex,id,if,pc}
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int IM_LO      = 8;
  localparam int IM_HI      = 15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } exc_state_e;

  // Any unmasked pending line, globally enabled and not already in exception level.
  function automatic logic int_pending(input logic [31:0] status,
                                       input logic [31:0] cause);
    return status[STATUS_IE] & ~status[STATUS_EXL] &
           (|(cause[IM_HI:IM_LO] & status[IM_HI:IM_LO]));
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Exception priority encoder (combinational).
// Ports:
//   flags     in   8   MEM-stage exception flags
//   int_pend  in   1   unmasked interrupt pending
//   mem_valid in   1   MEM stage holds a real instruction
//   code      out  32  excepttype of the highest-priority cause (0 = none)
//   take      out  1   an exception is taken this cycle
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic [7:0]  flags,
  input  logic        int_pend,
  input  logic        mem_valid,
  output logic [31:0] code,
  output logic        take
);

  // Bubbles never take anything, so an interrupt waits for a real instruction
  // and EPC always names a genuine PC.
  always_comb begin
    code = EXC_NONE;
    if (!mem_valid)                code = EXC_NONE;
    else if (int_pend)             code = EXC_INT;
    else if (flags[FLAG_ADEL_IF])  code = EXC_ADEL;
    else if (flags[FLAG_RI])       code = EXC_RI;
    else if (flags[FLAG_OV])       code = EXC_OV;
    else if (flags[FLAG_TRAP])     code = EXC_TRAP;
    else if (flags[FLAG_SYS])      code = EXC_SYS;
    else if (flags[FLAG_ADEL_D])   code = EXC_ADEL;
    else if (flags[FLAG_ADES])     code = EXC_ADES;
    else if (flags[FLAG_ERET])     code = EXC_ERET;
  end

  assign take = (code != EXC_NONE);

endmodule

// File: rtl/exc_ctrl.sv
// Pipeline exception/interrupt controller beside the MEM stage.
// Prioritises MEM exceptions and interrupts, drives the CP0 exception inputs,
// flushes and redirects the pipeline and merges stage stall requests.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   stallreq_id / stallreq_ex        stage stall requests
//   mem_valid, mem_pc, mem_in_delayslot, mem_exc_flags, mem_bad_addr  MEM stage info
//   cp0_status / cp0_cause / cp0_epc forwarded CP0 registers
//   excepttype_o, cur_inst_addr_o, in_delayslot_o, bad_addr_o         to CP0
//   stall_o, flush_o, redirect_o, new_pc_o                             to pipeline
//
// state    | meaning
// ST_IDLE  | normal operation; exceptions taken, stalls merged
// ST_FLUSH | extra flush cycles after a taken exception; inputs ignored
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic [7:0]  mem_exc_flags,
  input  logic [31:0] mem_bad_addr,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic [31:0] excepttype_o,
  output logic [31:0] cur_inst_addr_o,
  output logic        in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] new_pc_o
);

  localparam int              CNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  exc_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      code;
  logic             take;
  logic             int_pend;

  assign int_pend = int_pending(cp0_status, cp0_cause);

  exc_prio_enc u_prio (
    .flags     (mem_exc_flags),
    .int_pend  (int_pend),
    .mem_valid (mem_valid),
    .code      (code),
    .take      (take)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A single-cycle flush needs no FLUSH state at all.
          if (take && (FLUSH_CYCLES > 1)) begin
            state <= ST_FLUSH;
            cnt   <= CNT_LOAD;
          end
        end
        ST_FLUSH: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    excepttype_o    = EXC_NONE;
    cur_inst_addr_o = '0;
    in_delayslot_o  = 1'b0;
    bad_addr_o      = '0;
    stall_o         = STALL_NONE;
    flush_o         = 1'b0;
    redirect_o      = 1'b0;
    new_pc_o        = '0;
    if (!rst) begin
      cur_inst_addr_o = mem_pc;
      in_delayslot_o  = mem_in_delayslot;
      bad_addr_o      = mem_bad_addr;
      if (state == ST_FLUSH) begin
        // No retake here: CP0 EXL is still settling.
        flush_o = 1'b1;
      end else if (take) begin
        excepttype_o = code;
        flush_o      = 1'b1;
        redirect_o   = 1'b1;
        new_pc_o     = (code == EXC_ERET) ? cp0_epc : EXC_VECTOR;
      end else if (stallreq_ex) begin
        stall_o = STALL_EX;
      end else if (stallreq_id) begin
        stall_o = STALL_ID;
      end
    end
  end

endmodule
